bcd_seg_scanner: RTL and testbench
==================================

Name: bcd_seg_scanner

Overview:
- Downstream stage of the 4-digit BCD calculator.
- Consumes its five segment outputs: l4 is a 1-bit carry digit; l3..l0 are 7-bit segment patterns.
- Time-multiplexes them onto one shared 7-segment bus with a one-hot digit-select.
- Double-buffers the inputs so a display frame is never torn mid-scan.

Parameters:
- DIV_W, 16, width of the refresh prescaler counter.
- DIV_MAX, 49999, terminal count of the prescaler; one digit slot lasts DIV_MAX+1 clocks.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  scan enable; 0 blanks the display and freezes scanning.
- load  input  1  one-cycle strobe that captures l4..l0.
- l4  input  1  carry digit; 1 shows "1", 0 shows blank.
- l3, l2, l1, l0  input  7 each  segment patterns, bit6=a .. bit0=g, 1 = segment lit.
- an  output  5  one-hot digit select, active-high; bit0 = rightmost digit (l0), bit4 = carry digit.
- seg  output  7  segment drive for the selected digit, same bit order as l3..l0.
- frame_done  output  1  one-cycle pulse when the scan wraps from digit 4 to digit 0.

Behaviour:
- Reset values (applied on a clk edge with reset=1):
  - prescaler=0, index=0, pending=0, staging=0, shadow=0.
  - an=5'b00001, seg=7'b0000000, frame_done=0.
  - reset has priority over every other input.
- Prescaler:
  - Counts 0..DIV_MAX while en=1, then returns to 0.
  - tick = (prescaler==DIV_MAX) && en.
- Digit index (the scan state machine):
  - Sequence 0 -> 1 -> 2 -> 3 -> 4 -> 0; advances only on tick.
  - wrap = tick && index==4.
- Outputs are registered and update on the tick edge:
  - an = one-hot of the new index.
  - seg = shadow pattern of the new digit.
  - Digit 4 pattern is 7'b0110000 when shadow l4=1, else 7'b0000000.
  - The latency from an index change to the an/seg change is the same edge.
- Capture:
  - load=1 copies l4..l0 into staging and sets pending=1.
  - A later load before the next wrap overwrites staging; last value wins.
- Transfer (on a wrap edge):
  - If pending=1: shadow <= staging, pending <= 0.
  - Digit 0 shown on that same edge uses the new shadow value.
  - If load=1 on the wrap edge itself: shadow takes the live l4..l0 inputs directly (bypass) and pending is cleared.
- frame_done: registered; equals 1 for exactly the one cycle following a wrap edge.
- en=0:
  - Prescaler and index hold their values.
  - an=0 and seg=0 from the next edge on.
  - load still captures into staging, but no transfer happens.
- en returning to 1:
  - an/seg show the held index on the next edge.
  - The prescaler resumes from its held count.
- Reset mid-frame: all state is discarded and any pending load is lost.

Optional Feature:
- Macro: BCD_SCAN_LZB_EN.
- When defined, leading-zero blanking is applied at transfer time, when the patterns are written into shadow:
  - "Zero" means the pattern 7'b1111110.
  - l3 is blanked if l4=0 and l3 is zero.
  - l2 is blanked if l3 was blanked and l2 is zero.
  - l1 is blanked likewise, following l2.
  - l0 is never blanked.
- When undefined, patterns pass through unchanged.

Test Plan:
(All scenarios use DIV_MAX=3, i.e. 4 clocks per digit.)
- Reset, en=1, load with l4=0 and l3..l0=7'b1011011 ("5555") -> after the first wrap:
  - an steps 00001, 00010, 00100, 01000, 10000 every 4 clocks.
  - seg=1011011 on digits 0-3 and 0000000 on digit 4.
  - frame_done pulses once per 20 clocks.
- Overflow 9999+0001: load l4=1, l3..l0=1111110 -> digit 4 seg=0110000, digits 0-3 seg=1111110.
  - With BCD_SCAN_LZB_EN defined, the same values are still displayed, because l4=1.
- With BCD_SCAN_LZB_EN defined, load l4=0, l3=l2=1111110, l1=0110000, l0=1111110 -> digits 3 and 2 seg=0000000, digit 1=0110000, digit 0=1111110.
- Load new values while index=2 -> digits 3 and 4 still show the old values; the new values appear from digit 0 after the wrap.
  - Load asserted exactly on the wrap edge -> digit 0 shows the new l0 on that same edge.
- Drop en at index 3 for 10 clocks -> an=0 and seg=0 from the next edge; restoring en -> an=01000 with the remaining slot time preserved.
- Assert reset at index 3 with a load pending -> next cycle an=00001, seg=0, frame_done=0; the old staging value never appears.

Source files
------------

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: double-buffered 5-digit 7-segment scan driver.
// Define BCD_SCAN_LZB_EN to enable leading-zero blanking.
module bcd_seg_scanner #(
  parameter int DIV_W   = 16,
  parameter int DIV_MAX = 49999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic       l4,
  input  logic [6:0] l3,
  input  logic [6:0] l2,
  input  logic [6:0] l1,
  input  logic [6:0] l0,
  output logic [4:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    DIG0, DIG1, DIG2, DIG3, DIG4
  } idx_e;

  typedef struct packed {
    logic       c;
    logic [6:0] d3;
    logic [6:0] d2;
    logic [6:0] d1;
    logic [6:0] d0;
  } frame_t;

  localparam logic [6:0] SEG_ONE = 7'b0110000;
`ifdef BCD_SCAN_LZB_EN
  localparam logic [6:0] SEG_ZERO = 7'b1111110;
`endif

  logic [DIV_W-1:0] presc_q, presc_d;
  idx_e             idx_q, idx_d;
  logic             pend_q, pend_d;
  frame_t           stg_q, stg_d;
  frame_t           shd_q, shd_d;
  logic [4:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             fd_q, fd_d;
  logic             tick;
  logic             wrap;
  frame_t           live;

  // Blanking is applied once, when a frame is committed to shadow.
  function automatic frame_t lzb(frame_t f);
    frame_t r;
`ifdef BCD_SCAN_LZB_EN
    logic b3, b2, b1;
`endif
    r = f;
`ifdef BCD_SCAN_LZB_EN
    b3 = !f.c && (f.d3 == SEG_ZERO);
    b2 = b3 && (f.d2 == SEG_ZERO);
    b1 = b2 && (f.d1 == SEG_ZERO);
    if (b3) r.d3 = '0;
    if (b2) r.d2 = '0;
    if (b1) r.d1 = '0;
`endif
    return r;
  endfunction

  function automatic logic [6:0] pick(frame_t f, idx_e i);
    logic [6:0] p;
    p = '0;
    unique case (i)
      DIG0:    p = f.d0;
      DIG1:    p = f.d1;
      DIG2:    p = f.d2;
      DIG3:    p = f.d3;
      DIG4:    p = f.c ? SEG_ONE : 7'b0000000;
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic logic [4:0] onehot(idx_e i);
    logic [4:0] o;
    o = '0;
    unique case (i)
      DIG0:    o = 5'b00001;
      DIG1:    o = 5'b00010;
      DIG2:    o = 5'b00100;
      DIG3:    o = 5'b01000;
      DIG4:    o = 5'b10000;
      default: o = '0;
    endcase
    return o;
  endfunction

  assign live = {l4, l3, l2, l1, l0};

  // Scan FSM next state, capture/transfer and registered output drive.
  always_comb begin
    tick    = en && (presc_q == DIV_W'(DIV_MAX));
    wrap    = tick && (idx_q == DIG4);
    presc_d = presc_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    stg_d   = stg_q;
    shd_d   = shd_q;
    an_d    = '0;
    seg_d   = '0;
    fd_d    = wrap;

    if (en) begin
      presc_d = tick ? '0 : presc_q + DIV_W'(1);
    end

    if (tick) begin
      unique case (idx_q)
        DIG0:    idx_d = DIG1;
        DIG1:    idx_d = DIG2;
        DIG2:    idx_d = DIG3;
        DIG3:    idx_d = DIG4;
        DIG4:    idx_d = DIG0;
        default: idx_d = DIG0;
      endcase
    end

    if (load) begin
      stg_d  = live;
      pend_d = 1'b1;
    end

    // A load on the wrap edge bypasses staging so digit 0 is fresh.
    if (wrap) begin
      if (load) begin
        shd_d  = lzb(live);
        pend_d = 1'b0;
      end else if (pend_q) begin
        shd_d  = lzb(stg_q);
        pend_d = 1'b0;
      end
    end

    if (en) begin
      an_d  = onehot(idx_d);
      seg_d = pick(shd_d, idx_d);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= DIG0;
      pend_q  <= 1'b0;
      stg_q   <= '0;
      shd_q   <= '0;
      an_q    <= 5'b00001;
      seg_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      stg_q   <= stg_d;
      shd_q   <= shd_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// tb_bcd_seg_scanner: scoreboard bench for bcd_seg_scanner.
// Expected an/seg/frame_done are queued per cycle and checked by a monitor.
module tb_bcd_seg_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic       l4;
  logic [6:0] l3, l2, l1, l0;
  logic [4:0] an;
  logic [6:0] seg;
  logic       frame_done;

  always #5 clk = ~clk;

  bcd_seg_scanner #(
    .DIV_W  (16),
    .DIV_MAX(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .l4        (l4),
    .l3        (l3),
    .l2        (l2),
    .l1        (l1),
    .l0        (l0),
    .an        (an),
    .seg       (seg),
    .frame_done(frame_done)
  );

  typedef struct {
    int         c;
    logic [4:0] an;
    logic [6:0] seg;
    logic       fd;
    string      nm;
  } exp_t;

  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] PD = 7'b0000001;
  localparam logic [6:0] BL = 7'b0000000;
`ifdef BCD_SCAN_LZB_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = P0;
`endif

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   e0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.c != cyc || an !== e.an || seg !== e.seg
          || frame_done !== e.fd) begin
        errors++;
        $display("FAIL %s cyc=%0d/%0d an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                 e.nm, cyc, e.c, an, seg, frame_done, e.an, e.seg, e.fd);
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_to(int t);
    if (cyc > t) begin
      errors++;
      $display("FAIL sched cyc=%0d want<=%0d", cyc, t);
    end
    while (cyc < t) nxt();
  endtask

  task automatic ex(int c, logic [4:0] a, logic [6:0] s, logic f, string n);
    exp_t e;
    e.c = c; e.an = a; e.seg = s; e.fd = f; e.nm = n;
    sb.push_back(e);
  endtask

  task automatic drv(logic c, logic [6:0] d3, logic [6:0] d2,
                     logic [6:0] d1, logic [6:0] d0);
    l4 = c; l3 = d3; l2 = d2; l1 = d1; l0 = d0;
    load = 1'b1;
    nxt();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; load = 1'b0;
    l4 = 1'b0; l3 = '0; l2 = '0; l1 = '0; l0 = '0;
    nxt();
    nxt();

    e0 = cyc + 1;
    reset = 1'b1;
    en = 1'b1;
    ex(e0, 5'b00001, BL, 1'b0, "reset");
    nxt();
    reset = 1'b0;
    drv(1'b0, P5, P5, P5, P5);

    ex(e0 + 4,  5'b00010, BL, 1'b0, "prewrap_d1");
    ex(e0 + 20, 5'b00001, P5, 1'b1, "wrap_d0");
    ex(e0 + 21, 5'b00001, P5, 1'b0, "fd_clear");
    ex(e0 + 23, 5'b00001, P5, 1'b0, "slot_len");
    ex(e0 + 24, 5'b00010, P5, 1'b0, "d1");
    ex(e0 + 28, 5'b00100, P5, 1'b0, "d2");
    ex(e0 + 32, 5'b01000, P5, 1'b0, "d3");
    ex(e0 + 36, 5'b10000, BL, 1'b0, "d4_blank");
    ex(e0 + 39, 5'b10000, BL, 1'b0, "d4_hold");
    ex(e0 + 40, 5'b00001, P5, 1'b1, "wrap2");

    wait_to(e0 + 44);
    ex(e0 + 56, 5'b10000, BL, 1'b0, "ovf_old_c");
    ex(e0 + 60, 5'b00001, P0, 1'b1, "ovf_d0");
    ex(e0 + 64, 5'b00010, P0, 1'b0, "ovf_d1");
    ex(e0 + 72, 5'b01000, P0, 1'b0, "ovf_d3");
    ex(e0 + 76, 5'b10000, P1, 1'b0, "ovf_c");
    drv(1'b1, P0, P0, P0, P0);

    wait_to(e0 + 88);
    ex(e0 + 92,  5'b01000, P0, 1'b0, "mid_old_d3");
    ex(e0 + 96,  5'b10000, P1, 1'b0, "mid_old_c");
    ex(e0 + 100, 5'b00001, P0, 1'b1, "mid_new_d0");
    ex(e0 + 104, 5'b00010, P1, 1'b0, "mid_new_d1");
    ex(e0 + 108, 5'b00100, LZ, 1'b0, "lzb_d2");
    ex(e0 + 112, 5'b01000, LZ, 1'b0, "lzb_d3");
    ex(e0 + 116, 5'b10000, BL, 1'b0, "lzb_c");
    drv(1'b0, P0, P0, P1, P0);

    wait_to(e0 + 109);
    ex(e0 + 120, 5'b00001, P1, 1'b1, "bypass_d0");
    ex(e0 + 124, 5'b00010, P5, 1'b0, "bypass_d1");
    ex(e0 + 136, 5'b10000, BL, 1'b0, "bypass_c");
    ex(e0 + 140, 5'b00001, P1, 1'b1, "no_repend");
    drv(1'b0, PD, PD, PD, PD);
    wait_to(e0 + 119);
    drv(1'b0, P5, P5, P5, P1);

    ex(e0 + 153, 5'b01000, P5, 1'b0, "pre_pause");
    ex(e0 + 154, 5'b00000, BL, 1'b0, "pause_blank");
    ex(e0 + 163, 5'b00000, BL, 1'b0, "pause_hold");
    ex(e0 + 164, 5'b01000, P5, 1'b0, "resume_d3");
    ex(e0 + 165, 5'b01000, P5, 1'b0, "resume_slot");
    ex(e0 + 166, 5'b10000, BL, 1'b0, "resume_d4");
    ex(e0 + 170, 5'b00001, P0, 1'b1, "pause_load");
    wait_to(e0 + 153);
    en = 1'b0;
    wait_to(e0 + 157);
    drv(1'b1, P0, P0, P0, P0);
    wait_to(e0 + 163);
    en = 1'b1;

    wait_to(e0 + 180);
    ex(e0 + 182, 5'b01000, P0, 1'b0, "prereset_d3");
    ex(e0 + 183, 5'b00001, BL, 1'b0, "mid_reset");
    ex(e0 + 203, 5'b00001, BL, 1'b1, "no_stale_d0");
    ex(e0 + 207, 5'b00010, BL, 1'b0, "no_stale_d1");
    drv(1'b0, PD, PD, PD, PD);
    wait_to(e0 + 182);
    reset = 1'b1;
    l4 = 1'b1; l3 = P5; l2 = P5; l1 = P5; l0 = P5;
    load = 1'b1;
    nxt();
    reset = 1'b0;
    load = 1'b0;

    wait_to(e0 + 210);
    for (int i = 0; i < 20 && sb.size() > 0; i++) nxt();
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
